// File: rtl/regfile_write_arbiter.sv
// Write-side front end of the 1W/N-read register file: round-robin merge of N_WR
// requesters onto one registered write port, preceded by an init sweep of every row.
module regfile_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned W_N_ROWS   = 2 ** ADDR_WIDTH,
    parameter int unsigned N_WR       = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init_req_i,
    input  logic [N_WR-1:0]              wr_valid_i,
    output logic [N_WR-1:0]              wr_ready_o,
    input  logic [N_WR*ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [N_WR*DATA_WIDTH-1:0]   wr_data_i,
    output logic                         init_done_o,
    output logic                         addr_err_o,
    output logic                         WriteEnable,
    output logic [ADDR_WIDTH-1:0]        WriteAddr,
    output logic [DATA_WIDTH-1:0]        WriteData
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned RR_W  = (N_WR > 1) ? $clog2(N_WR) : 1;
    localparam logic [PTR_W-1:0] ROWS = PTR_W'(W_N_ROWS);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [RR_W-1:0]        rr_q, rr_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   gfound;
    logic [RR_W-1:0]        gidx;
    logic [RR_W-1:0]        cand;
    logic                   xfer;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   in_range;

    // Round-robin search: first valid requester at or after rr_q, wrapping.
    always_comb begin
        gfound = 1'b0;
        gidx   = rr_q;
        cand   = rr_q;
        for (int k = 0; k < int'(N_WR); k++) begin
            cand = RR_W'((int'(rr_q) + k) % int'(N_WR));
            if (!gfound && wr_valid_i[cand]) begin
                gfound = 1'b1;
                gidx   = cand;
            end
        end
    end

    assign xfer = (state_q == ST_RUN) && !init_req_i && gfound;

    always_comb begin
        wr_ready_o = '0;
        sel_addr   = '0;
        sel_data   = '0;
        for (int i = 0; i < int'(N_WR); i++) begin
            if (gidx == RR_W'(i)) begin
                wr_ready_o[i] = xfer;
                sel_addr      = wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data      = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_range = ({1'b0, sel_addr} < ROWS);

    // Next-state: the sweep issues rows 0..W_N_ROWS-1, then one cycle later enters RUN
    // together with init_done, so requests are only granted once init_done is visible.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rr_d    = rr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                done_d = 1'b0;
                if (ptr_q < ROWS) begin
                    we_d    = 1'b1;
                    waddr_d = ADDR_WIDTH'(ptr_q);
                    wdata_d = INIT_VALUE;
                    ptr_d   = ptr_q + PTR_W'(1);
                end else begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (init_req_i) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    done_d  = 1'b0;
                end else if (xfer) begin
                    rr_d = RR_W'((int'(gidx) + 1) % int'(N_WR));
                    if (in_range) begin
                        we_d    = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            rr_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign WriteEnable = we_q;
    assign WriteAddr   = waddr_q;
    assign WriteData   = wdata_q;
    assign init_done_o = done_q;
    assign addr_err_o  = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter: a cycle-level reference model
// predicts sweep/grant/write events; a monitor pops them as the write port presents them.
module tb_regfile_write_arbiter;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned ROWS = 20;
    localparam int unsigned NW   = 2;
    localparam logic [DW-1:0] INIT_V = 32'h5A5A_0F0F;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 init_req_i;
    logic [NW-1:0]        wr_valid_i;
    logic [NW-1:0]        wr_ready_o;
    logic [NW*AW-1:0]     wr_addr_i;
    logic [NW*DW-1:0]     wr_data_i;
    logic                 init_done_o;
    logic                 addr_err_o;
    logic                 WriteEnable;
    logic [AW-1:0]        WriteAddr;
    logic [DW-1:0]        WriteData;

    regfile_write_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .W_N_ROWS(ROWS), .N_WR(NW), .INIT_VALUE(INIT_V)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_req_i(init_req_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .init_done_o(init_done_o), .addr_err_o(addr_err_o),
        .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          err;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: run flag, sweep row count, round-robin pointer, requester holds.
    bit            m_run;
    int            m_k;
    int            m_rr;
    bit            pend [NW];
    logic [AW-1:0] p_addr [NW];
    logic [DW-1:0] p_data [NW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && (WriteEnable || addr_err_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {WriteEnable, addr_err_o}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("write_enable", WriteEnable, !e.err);
                check("addr_err", addr_err_o, e.err);
                if (!e.err) begin
                    check("write_addr", WriteAddr, e.addr);
                    check("write_data", WriteData, e.data);
                end
            end
        end
    end

    // One model cycle, entered at a falling edge: drive, settle, predict, compare.
    task automatic body(input int p_new, input int p_init);
        wr_t          e;
        logic [NW-1:0] exp_rdy;
        for (int i = 0; i < int'(NW); i++) begin
            if (!pend[i] && $urandom_range(99) < p_new) begin
                pend[i]   = 1'b1;
                p_addr[i] = AW'($urandom_range(31));
                p_data[i] = $urandom;
            end
            wr_valid_i[i]            = pend[i];
            wr_addr_i[i*AW +: AW]    = p_addr[i];
            wr_data_i[i*DW +: DW]    = p_data[i];
        end
        init_req_i = ($urandom_range(99) < p_init);
        #1;
        check("init_done", init_done_o, m_run);
        exp_rdy = '0;
        if (!m_run) begin
            if (m_k < int'(ROWS)) begin
                e.err = 1'b0; e.addr = AW'(m_k); e.data = INIT_V;
                exp_q.push_back(e);
                m_k++;
            end else begin
                m_run = 1'b1;
            end
        end else if (init_req_i) begin
            m_run = 1'b0;
            m_k   = 0;
        end else begin
            for (int k = 0; k < int'(NW); k++) begin
                int c;
                c = (m_rr + k) % int'(NW);
                if (pend[c]) begin
                    exp_rdy[c] = 1'b1;
                    e.err  = (int'(p_addr[c]) >= int'(ROWS));
                    e.addr = p_addr[c];
                    e.data = p_data[c];
                    exp_q.push_back(e);
                    pend[c] = 1'b0;
                    m_rr    = (c + 1) % int'(NW);
                    break;
                end
            end
        end
        check("wr_ready", wr_ready_o, exp_rdy);
    endtask

    task automatic step(input int p_new, input int p_init);
        @(negedge clk);
        body(p_new, p_init);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run = 1'b0;
        m_k   = 0;
        m_rr  = 0;
    endtask

    initial begin
        rst_n      = 1'b0;
        init_req_i = 1'b0;
        wr_valid_i = '0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        for (int i = 0; i < int'(NW); i++) begin
            pend[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_we", WriteEnable, 0);
        check("rst_addr", WriteAddr, 0);
        check("rst_data", WriteData, 0);
        check("rst_done", init_done_o, 0);
        check("rst_err", addr_err_o, 0);

        @(negedge clk);
        rst_n = 1'b1;
        body(50, 0);
        repeat (30)  step(50, 5);
        repeat (300) step(60, 2);
        repeat (100) step(100, 0);

        // Async reset in the middle of a restarted sweep.
        for (int n = 0; n < 50 && !m_run; n++) step(50, 0);
        step(50, 100);
        repeat (11) step(50, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", WriteEnable, 0);
        check("arst_addr", WriteAddr, 0);
        check("arst_data", WriteData, 0);
        check("arst_done", init_done_o, 0);
        check("arst_ready", wr_ready_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        body(50, 0);
        repeat (300) step(40, 3);
        repeat (60)  step(0, 0);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
